seq_mul_32: RTL
===============

SEQ_MUL_32 -- requirements
Module: seq_mul_32

Interface
REQ-001 SHALL provide the following ports, one per line: name, direction, width, meaning.
- clk        input   1   single clock; all state changes on its rising edge.
- reset      input   1   asynchronous, active-high reset.
- start      input   1   request a multiply; sampled only in IDLE.
- S_MUL      input   32  multiplicand, two's complement.
- T_MUL      input   32  multiplier, two's complement.
- Y_HI       output  32  product bits [63:32].
- Y_LO       output  32  product bits [31:0].
- N_MUL      output  1   negative flag, equal to product[63].
- Z_MUL      output  1   zero flag, set when the full 64-bit product is zero.
- busy       output  1   operation in progress.
- done       output  1   one-cycle pulse when the result is valid.
REQ-002 SHALL use one clock, clk; reset SHALL be asynchronous and active-high.

Function
REQ-003 SHALL have exactly three states:
- IDLE: waiting for start.
- RUN: shift-add iterations.
- FIX: sign correction and result write.
REQ-004 On the rising edge where state = IDLE and start = 1 (edge E0), SHALL:
- capture |S_MUL| and |T_MUL| as 32-bit unsigned magnitudes;
- capture the result sign, S_MUL[31] XOR T_MUL[31];
- clear the 64-bit accumulator and the 6-bit iteration counter;
- enter RUN.
REQ-005 In RUN, each edge SHALL perform one radix-2 shift-add step: if the current multiplier LSB is 1, add the multiplicand magnitude into the upper accumulator half; then shift right by one.
REQ-006 RUN SHALL last exactly 32 edges (E1..E32); the edge where the counter equals 31 SHALL transition to FIX.
REQ-007 At edge E33 in FIX, SHALL:
- two's-complement negate the 64-bit magnitude if the sign is set;
- register Y_HI, Y_LO, N_MUL and Z_MUL;
- pulse done for exactly one cycle;
- return to IDLE.
REQ-008 busy SHALL be 1 exactly while state ≠ IDLE; done SHALL never be 1 while busy is 1.
REQ-009 start while busy SHALL be ignored without side effects; operand changes after E0 SHALL NOT affect the result.
REQ-010 start asserted in the cycle done is high SHALL be accepted, giving back-to-back operations with a 34-cycle issue interval.
REQ-011 Y_HI, Y_LO, N_MUL and Z_MUL SHALL hold their last values until the next FIX edge.
REQ-012 0x80000000 operands SHALL produce magnitude 2^31 without overflow; results SHALL be exact for all 2^64 operand pairs.
REQ-013 Latency SHALL be fixed at 34 edges from acceptance to the done pulse, independent of operand values; there is no early termination.

Reset
REQ-014 While reset = 1, regardless of clk:
- state SHALL be IDLE and busy = 0, done = 0;
- Y_HI, Y_LO and the internal datapath SHALL be 0;
- N_MUL = 0 and Z_MUL = 0.
REQ-015 Reset asserted mid-operation SHALL abort the operation; no done pulse SHALL follow for it.
REQ-016 After reset deasserts, the first rising edge with start = 1 SHALL be accepted.

Configuration
REQ-017 Macro SEQ_MUL_UNSIGNED_EN compiled in: SHALL add input port unsigned_op (1 bit, sampled at E0). When unsigned_op = 1, SHALL:
- skip magnitude conversion and sign correction;
- treat both operands as unsigned (MULTU behaviour);
- set N_MUL = product[63] as before.
REQ-018 Macro absent: the unsigned_op port SHALL not exist and all operations SHALL be signed.

Structure
REQ-019 Shared package SHALL hold:
- the state enum (IDLE, RUN, FIX);
- the data-width constant, 32;
- the counter-width constant, 6;
- the iteration-count constant, 32.
REQ-020 SHALL be a single module; no sub-module. The datapath is one 33-bit adder plus shift registers.

Verification
REQ-021 3 × 4 -> Y_HI = 0x00000000, Y_LO = 0x0000000C, N_MUL = 0, Z_MUL = 0; done exactly 34 edges after the start edge.
REQ-022 0xFFFFFFFD × 0x00000004 -> Y_HI = 0xFFFFFFFF, Y_LO = 0xFFFFFFF4, N_MUL = 1.
REQ-023 0x80000000 × 0x80000000 -> Y_HI = 0x40000000, Y_LO = 0x00000000, N_MUL = 0; also 0x12345678 × 0 -> Z_MUL = 1.
REQ-024 Re-pulse start with new operands at edge E10 -> ignored, first result unchanged. Then reset at E20 -> busy = 0, all outputs 0, no done.
REQ-025 Back-to-back case: 5 × 5, with the next start during done for 7 × −1 -> results 25, then Y_HI = 0xFFFFFFFF, Y_LO = 0xFFFFFFF9, 34 cycles apart.
REQ-026 With SEQ_MUL_UNSIGNED_EN and unsigned_op = 1: 0xFFFFFFFF × 0xFFFFFFFF -> Y_HI = 0xFFFFFFFE, Y_LO = 0x00000001, N_MUL = 1.

Source files
------------

// File: rtl/seq_mul_32_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_mul_32_pkg
// Description : Shared types and constants for the 32x32 sequential multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_mul_32_pkg;

    localparam int c_data_w = 32;
    localparam int c_cnt_w  = 6;
    localparam int c_iter   = 32;

    localparam logic [c_cnt_w-1:0] c_last_iter = c_cnt_w'(c_iter - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    // 0x80000000 maps to 0x80000000, which is 2^31 read as unsigned.
    function automatic logic [c_data_w-1:0] mag(input logic [c_data_w-1:0] v);
        return v[c_data_w-1] ? (~v + c_data_w'(1)) : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_mul_32.sv
`default_nettype none
// ============================================================================
// Module      : seq_mul_32
// Description : Radix-2 shift-add 32x32 signed multiplier, fixed 34-edge
//               latency. Optional macro SEQ_MUL_UNSIGNED_EN adds unsigned_op.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_mul_32
    import seq_mul_32_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [c_data_w-1:0] S_MUL,
    input  logic [c_data_w-1:0] T_MUL,
`ifdef SEQ_MUL_UNSIGNED_EN
    input  logic                unsigned_op,
`endif
    output logic [c_data_w-1:0] Y_HI,
    output logic [c_data_w-1:0] Y_LO,
    output logic                N_MUL,
    output logic                Z_MUL,
    output logic                busy,
    output logic                done
);

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [c_data_w-1:0]       r_mcand;
    logic [c_data_w-1:0]       r_mplier;
    logic                      r_sign;
    logic [2*c_data_w-1:0]     r_acc;
    logic [c_cnt_w-1:0]        r_cnt;
    logic [c_data_w-1:0]       r_y_hi;
    logic [c_data_w-1:0]       r_y_lo;
    logic                      r_n;
    logic                      r_z;
    logic                      r_done;

    logic                      w_accept;
    logic [c_data_w-1:0]       w_op_mcand;
    logic [c_data_w-1:0]       w_op_mplier;
    logic                      w_op_sign;
    logic [c_data_w-1:0]       w_addend;
    logic [c_data_w:0]         w_sum;
    logic [2*c_data_w-1:0]     w_prod;

    assign w_accept = (r_state == IDLE) && start;

`ifdef SEQ_MUL_UNSIGNED_EN
    assign w_op_mcand  = unsigned_op ? S_MUL : mag(S_MUL);
    assign w_op_mplier = unsigned_op ? T_MUL : mag(T_MUL);
    assign w_op_sign   = unsigned_op ? 1'b0  : (S_MUL[c_data_w-1] ^ T_MUL[c_data_w-1]);
`else
    assign w_op_mcand  = mag(S_MUL);
    assign w_op_mplier = mag(T_MUL);
    assign w_op_sign   = S_MUL[c_data_w-1] ^ T_MUL[c_data_w-1];
`endif

    // The single 33-bit adder: carry out becomes the new top bit after the shift.
    assign w_addend = r_mplier[0] ? r_mcand : '0;
    assign w_sum    = {1'b0, r_acc[2*c_data_w-1:c_data_w]} + {1'b0, w_addend};
    assign w_prod   = r_sign ? (~r_acc + (2*c_data_w)'(1)) : r_acc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = RUN;
            RUN:     if (r_cnt == c_last_iter) w_state_nxt = FIX;
            FIX:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_sign   <= 1'b0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_y_hi   <= '0;
            r_y_lo   <= '0;
            r_n      <= 1'b0;
            r_z      <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= (r_state == FIX);
            if (w_accept) begin
                r_mcand  <= w_op_mcand;
                r_mplier <= w_op_mplier;
                r_sign   <= w_op_sign;
                r_acc    <= '0;
                r_cnt    <= '0;
            end else if (r_state == RUN) begin
                r_acc    <= {w_sum, r_acc[c_data_w-1:1]};
                r_mplier <= {1'b0, r_mplier[c_data_w-1:1]};
                r_cnt    <= r_cnt + c_cnt_one;
            end else if (r_state == FIX) begin
                r_y_hi <= w_prod[2*c_data_w-1:c_data_w];
                r_y_lo <= w_prod[c_data_w-1:0];
                r_n    <= w_prod[2*c_data_w-1];
                r_z    <= (w_prod == '0);
            end
        end
    end

    assign Y_HI  = r_y_hi;
    assign Y_LO  = r_y_lo;
    assign N_MUL = r_n;
    assign Z_MUL = r_z;
    assign busy  = (r_state != IDLE);
    assign done  = r_done;

endmodule
`default_nettype wire
